// File: rtl/irrigation_sequencer.sv
// Irrigation valve sequencer: one sprinkler/drip channel open at a time with a
// minimum on-time and a closed gap between channels, plus an independent tank-fill timeout guard.
module irrigation_sequencer #(
    parameter int MIN_ON       = 4,
    parameter int SWITCH_GAP   = 2,
    parameter int FILL_TIMEOUT = 10,
    parameter int CNT_W        = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       asp_req,
    input  logic       got_req,
    input  logic       fill_req,
    input  logic       error_in,
    input  logic       fault_clr,
    output logic       asp_valve,
    output logic       got_valve,
    output logic       fill_valve,
    output logic       fill_fault,
    output logic       alarm,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ASP_ON = 3'd1,
        GOT_ON = 3'd2,
        GAP    = 3'd3,
        FAULT  = 3'd4
    } state_t;

    // Counters are loaded with (length - 1) and the phase ends on the edge that sees zero.
    localparam logic [CNT_W-1:0] ON_LOAD  = CNT_W'(MIN_ON - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(SWITCH_GAP - 1);
    localparam logic [CNT_W-1:0] FILL_LIM = CNT_W'(FILL_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    state_t           st;
    logic [CNT_W-1:0] on_cnt;
    logic [CNT_W-1:0] gap_cnt;
    logic [CNT_W-1:0] fill_cnt;
    logic             timeout;
    logic             fault_nx;

    assign state = st;

    // fill_cnt holds the open cycles already completed, so the current cycle is the last allowed one at FILL_LIM.
    always_comb begin
        timeout  = fill_valve && (fill_cnt >= FILL_LIM);
        fault_nx = timeout || (fill_fault && !fault_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st        <= IDLE;
            asp_valve <= 1'b0;
            got_valve <= 1'b0;
            alarm     <= 1'b0;
            on_cnt    <= '0;
            gap_cnt   <= '0;
        end else begin
            asp_valve <= 1'b0;
            got_valve <= 1'b0;
            alarm     <= fault_nx;
            if (error_in) begin
                st    <= FAULT;
                alarm <= 1'b1;
            end else begin
                case (st)
                    IDLE: begin
                        if (asp_req) begin
                            st        <= ASP_ON;
                            asp_valve <= 1'b1;
                            on_cnt    <= ON_LOAD;
                        end else if (got_req) begin
                            st        <= GOT_ON;
                            got_valve <= 1'b1;
                            on_cnt    <= ON_LOAD;
                        end
                    end
                    ASP_ON: begin
                        if (on_cnt != '0) begin
                            on_cnt    <= on_cnt - ONE;
                            asp_valve <= 1'b1;
                        end else if (asp_req) begin
                            asp_valve <= 1'b1;
                        end else begin
                            st      <= GAP;
                            gap_cnt <= GAP_LOAD;
                        end
                    end
                    GOT_ON: begin
                        if (on_cnt != '0) begin
                            on_cnt    <= on_cnt - ONE;
                            got_valve <= 1'b1;
                        end else if (got_req) begin
                            got_valve <= 1'b1;
                        end else begin
                            st      <= GAP;
                            gap_cnt <= GAP_LOAD;
                        end
                    end
                    GAP: begin
                        if (gap_cnt == '0) st <= IDLE;
                        else               gap_cnt <= gap_cnt - ONE;
                    end
                    FAULT: begin
                        st      <= GAP;
                        gap_cnt <= GAP_LOAD;
                    end
                    default: st <= IDLE;
                endcase
            end
        end
    end

    // Fill path: the timeout set beats an operator clear on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_valve <= 1'b0;
            fill_fault <= 1'b0;
            fill_cnt   <= '0;
        end else begin
            fill_valve <= !timeout && fill_req && !error_in && !fill_fault;
            fill_fault <= fault_nx;
            if (!fill_valve)          fill_cnt <= '0;
            else if (fill_cnt != '1) fill_cnt <= fill_cnt + ONE;
        end
    end

endmodule

// File: tb/tb_irrigation_sequencer.sv
// Bench for irrigation_sequencer: directed scenarios with literal checks plus
// a per-cycle comparison against an elapsed-time model of the valve rules.
module tb_irrigation_sequencer;

    localparam int MIN_ON       = 4;
    localparam int SWITCH_GAP   = 2;
    localparam int FILL_TIMEOUT = 10;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b1;
    logic       asp_req   = 1'b0;
    logic       got_req   = 1'b0;
    logic       fill_req  = 1'b0;
    logic       error_in  = 1'b0;
    logic       fault_clr = 1'b0;
    logic       asp_valve, got_valve, fill_valve, fill_fault, alarm;
    logic [2:0] state;

    int n_cmp = 0;
    int n_bad = 0;
    bit check_en = 1'b0;

    irrigation_sequencer #(
        .MIN_ON(MIN_ON), .SWITCH_GAP(SWITCH_GAP), .FILL_TIMEOUT(FILL_TIMEOUT), .CNT_W(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .asp_req(asp_req), .got_req(got_req),
        .fill_req(fill_req), .error_in(error_in), .fault_clr(fault_clr),
        .asp_valve(asp_valve), .got_valve(got_valve), .fill_valve(fill_valve),
        .fill_fault(fill_fault), .alarm(alarm), .state(state)
    );

    always #5 clk = ~clk;

    // Model: which channel is open and how many cycles each phase has already lasted.
    int m_state, m_open, m_gap, m_run;
    bit m_fill, m_fault, m_alarm, m_own, m_to, m_nf, m_nv;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state = 0; m_open = 0; m_gap = 0; m_run = 0;
            m_fill = 0; m_fault = 0; m_alarm = 0;
        end else begin
            if (error_in) m_state = 4;
            else case (m_state)
                0: if (asp_req) begin m_state = 1; m_open = 1; end
                   else if (got_req) begin m_state = 2; m_open = 1; end
                1, 2: begin
                    m_own = (m_state == 1) ? asp_req : got_req;
                    if (m_open >= MIN_ON && !m_own) begin m_state = 3; m_gap = 1; end
                    else m_open++;
                end
                3: if (m_gap >= SWITCH_GAP) m_state = 0; else m_gap++;
                default: begin m_state = 3; m_gap = 1; end
            endcase
            if (m_fill) m_run++; else m_run = 0;
            m_to  = m_fill && (m_run >= FILL_TIMEOUT);
            m_nf  = m_to || (m_fault && !fault_clr);
            m_nv  = !m_to && fill_req && !error_in && !m_fault;
            m_fault = m_nf;
            m_fill  = m_nv;
            m_alarm = m_fault || (m_state == 4);
        end
    end

    logic [7:0] outs, m_vec;
    assign outs  = {state, asp_valve, got_valve, fill_valve, fill_fault, alarm};
    assign m_vec = {3'(m_state), m_state == 1, m_state == 2, m_fill, m_fault, m_alarm};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) check("cycle_model", 32'(outs), 32'(m_vec));
    end

    task automatic tick();
        @(negedge clk);
    endtask

    int exp_pulse[8]   = '{1, 1, 1, 1, 3, 3, 0, 0};
    int exp_handover[4] = '{3, 3, 0, 2};
    int exp_recover[3] = '{3, 3, 0};
    int cnt;

    initial begin
        #1 rst_n = 1'b0;
        check_en = 1'b1;
        repeat (2) tick();
        check("reset_outputs", 32'(outs), 32'd0);
        rst_n = 1'b1;
        tick();

        // One-cycle sprinkler request: minimum on-time, then the gap.
        asp_req = 1'b1;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            asp_req = 1'b0;
            check("asp_pulse_state", 32'(state), 32'(exp_pulse[i]));
            cnt += int'(asp_valve);
        end
        check("asp_pulse_open_cycles", 32'(cnt), 32'd4);

        // Both requests: sprinkler wins and holds; drip follows only after the gap.
        asp_req = 1'b1; got_req = 1'b1;
        tick();
        check("both_req_state", 32'(state), 32'd1);
        repeat (6) tick();
        check("both_req_valves", 32'({asp_valve, got_valve}), 32'b10);
        asp_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("handover_state", 32'(state), 32'(exp_handover[i]));
        end
        check("handover_got_open", 32'({asp_valve, got_valve}), 32'b01);
        repeat (4) tick();
        got_req = 1'b0;
        repeat (5) tick();
        check("handover_idle", 32'(state), 32'd0);

        // Level error while drip is open.
        got_req = 1'b1;
        repeat (2) tick();
        check("drip_open", 32'(got_valve), 32'd1);
        error_in = 1'b1;
        tick();
        check("error_fault", 32'({state, got_valve, alarm}), 32'({3'd4, 1'b0, 1'b1}));
        got_req = 1'b0;
        tick();
        check("error_hold", 32'(state), 32'd4);
        error_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("error_recover_state", 32'(state), 32'(exp_recover[i]));
        end
        check("error_recover_alarm", 32'(alarm), 32'd0);

        // Fill timeout, then acknowledge.
        fill_req = 1'b1;
        cnt = 0;
        repeat (15) begin
            tick();
            cnt += int'(fill_valve);
        end
        check("fill_open_cycles", 32'(cnt), 32'd10);
        check("fill_timeout_flags", 32'({fill_valve, fill_fault, alarm}), 32'b011);
        fault_clr = 1'b1;
        tick();
        check("fill_clear", 32'({fill_valve, fill_fault, alarm}), 32'b000);
        fault_clr = 1'b0;
        tick();
        check("fill_reopen", 32'(fill_valve), 32'd1);
        fill_req = 1'b0;
        repeat (2) tick();

        // Clear arriving on the timeout edge loses to the set.
        fill_req = 1'b1;
        repeat (10) tick();
        check("fill_last_open", 32'(fill_valve), 32'd1);
        fault_clr = 1'b1;
        tick();
        check("clr_vs_timeout", 32'({fill_valve, fill_fault}), 32'b01);
        tick();
        check("clr_after_timeout", 32'(fill_fault), 32'd0);
        fault_clr = 1'b0; fill_req = 1'b0;
        repeat (2) tick();

        // Level error also shuts the fill valve.
        fill_req = 1'b1;
        tick();
        error_in = 1'b1;
        tick();
        check("error_blocks_fill", 32'({state, fill_valve}), 32'({3'd4, 1'b0}));
        error_in = 1'b0; fill_req = 1'b0;
        repeat (4) tick();

        // Asynchronous reset mid-operation.
        asp_req = 1'b1; fill_req = 1'b1;
        repeat (12) tick();
        check("pre_reset_busy", 32'({asp_valve, fill_fault}), 32'b11);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check("async_reset", 32'(outs), 32'd0);
        asp_req = 1'b0; fill_req = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        check("post_reset_idle", 32'(state), 32'd0);
        got_req = 1'b1;
        tick();
        got_req = 1'b0;
        check("post_reset_drip", 32'({state, got_valve}), 32'({3'd2, 1'b1}));
        repeat (8) tick();

        check_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/irrigation_sequencer.md
IRRIGATION_SEQUENCER -- requirements
Module: irrigation_sequencer

Interface
REQ-001 Parameter MIN_ON, default 4: minimum consecutive cycles an irrigation valve stays open once opened.
REQ-002 Parameter SWITCH_GAP, default 2: cycles spent in GAP with both irrigation valves closed after a channel closes.
REQ-003 Parameter FILL_TIMEOUT, default 10: maximum consecutive cycles fill_valve may stay open before a fill fault.
REQ-004 Parameter CNT_W, default 8: width of every internal counter; MIN_ON, SWITCH_GAP and FILL_TIMEOUT shall be 1..2^CNT_W-1.
REQ-005 clk  input  1  single system clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 asp_req  input  1  sprinkler request from the irrigation decision logic.
REQ-008 got_req  input  1  drip request from the irrigation decision logic.
REQ-009 fill_req  input  1  tank fill request (water-supply decision).
REQ-010 error_in  input  1  level-sensor inconsistency flag from the level checker.
REQ-011 fault_clr  input  1  operator acknowledge; clears a latched fill fault.
REQ-012 asp_valve  output  1  sprinkler valve drive, registered.
REQ-013 got_valve  output  1  drip valve drive, registered.
REQ-014 fill_valve  output  1  tank inlet valve drive, registered.
REQ-015 fill_fault  output  1  sticky fill-timeout flag, registered.
REQ-016 alarm  output  1  high when fill_fault=1 or FSM is in FAULT.
REQ-017 state  output  3  FSM encoding: IDLE=0, ASP_ON=1, GOT_ON=2, GAP=3, FAULT=4.

Function
REQ-018 The FSM shall have exactly five states: IDLE, ASP_ON, GOT_ON, GAP, FAULT.
REQ-019 Valve outputs shall be Moore-decoded from registered state: asp_valve=1 only in ASP_ON, got_valve=1 only in GOT_ON; both are never 1 in the same cycle.
REQ-020 From any state, error_in=1 at a rising edge shall move the FSM to FAULT; this takes priority over every other transition.
REQ-021 FAULT shall hold while error_in=1; the first edge with error_in=0 moves the FSM to GAP and loads the gap counter.
REQ-022 In IDLE: asp_req=1 -> ASP_ON; else got_req=1 -> GOT_ON; else stay in IDLE; asp_req wins if both are high.
REQ-023 Entering ASP_ON or GOT_ON shall load the on-counter so the valve is high for at least MIN_ON consecutive cycles.
REQ-024 In ASP_ON/GOT_ON the FSM shall leave to GAP only after MIN_ON cycles have elapsed and its own request is 0; with the request held, the valve stays open indefinitely.
REQ-025 A request for the other channel shall not preempt an open channel; it is served only via GAP -> IDLE.
REQ-026 GAP shall last exactly SWITCH_GAP cycles and then go to IDLE, giving at least SWITCH_GAP+1 closed cycles between two openings.
REQ-027 Request-to-valve latency from IDLE shall be 1 cycle: a request sampled at edge n gives valve=1 after edge n.
REQ-028 fill_valve next value = fill_req & ~error_in & ~fill_fault, independent of the irrigation FSM.
REQ-029 The fill counter shall count consecutive cycles with fill_valve=1, clear whenever fill_valve=0, and saturate rather than wrap.
REQ-030 After FILL_TIMEOUT consecutive open cycles, the next edge shall set fill_fault=1 and force fill_valve=0.
REQ-031 fill_fault shall stay set until fault_clr=1 at an edge or reset; fill_valve may reopen at the following edge if fill_req=1.
REQ-032 Simultaneous fault_clr and a timeout on the same edge: the fault is set, because the set wins.
REQ-033 alarm shall be registered, consistent with the same-cycle state and fill_fault values.

Reset
REQ-034 rst_n=0 shall immediately, without waiting for clk, force state=IDLE, all valves=0, fill_fault=0, alarm=0 and all counters=0.
REQ-035 A reset asserted mid-operation (a valve open, or in GAP or FAULT) shall abort the operation; after release the block behaves as freshly reset.

Verification (defaults: MIN_ON=4, SWITCH_GAP=2, FILL_TIMEOUT=10)
REQ-036 asp_req pulsed for 1 cycle -> asp_valve high exactly 4 cycles, state 3 for 2 cycles, then state 0.
REQ-037 asp_req and got_req both held high -> asp_valve opens, got_valve stays 0; drop asp_req -> asp_valve closes, got_valve rises 3 cycles later.
REQ-038 error_in raised while got_valve=1 -> next edge got_valve=0, state=4, alarm=1; error_in dropped -> GAP for 2 cycles, then IDLE.
REQ-039 fill_req held 15 cycles -> fill_valve high 10 cycles, then 0 with fill_fault=1 and alarm=1; fault_clr pulse -> fill_fault=0, and fill_valve reopens one cycle later.
REQ-040 rst_n driven low between clock edges while asp_valve=1 and fill_fault=1 -> all outputs 0 before the next clk edge.
